// File: rtl/riscv_pkg.sv
// Shared encodings for the data-memory responder: access-size codes and FSM states.
package riscv_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data, extended load data, misalignment.
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_aligned,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  assign byte_sh = rword >> {addr_lo, 3'b000};
  assign half_sh = rword >> {addr_lo[1], 4'b0000};

  always_comb begin
    byte_en       = 4'b0000;
    wdata_aligned = 32'h0;
    rdata_ext     = 32'h0;
    misalign      = 1'b0;
    case (size)
      SZ_BYTE: begin
        byte_en       = 4'b0001 << addr_lo;
        wdata_aligned = {4{wdata[7:0]}};
        rdata_ext     = is_unsigned ? {24'h0, byte_sh[7:0]}
                                    : {{24{byte_sh[7]}}, byte_sh[7:0]};
      end
      SZ_HALF: begin
        misalign      = addr_lo[0];
        byte_en       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_aligned = {2{wdata[15:0]}};
        rdata_ext     = is_unsigned ? {16'h0, half_sh[15:0]}
                                    : {{16{half_sh[15]}}, half_sh[15:0]};
      end
      SZ_WORD: begin
        misalign      = (addr_lo != 2'b00);
        byte_en       = 4'b1111;
        wdata_aligned = wdata;
        rdata_ext     = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory with WAIT_STATES latency over valid/ready request and response channels.
// Define DMEM_BACK2BACK_EN to let a new request be accepted in the cycle a response is consumed.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  logic [31:0] memory [0:DEPTH-1];

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic          accept;
  logic          commit_from_req;
  logic          commit_from_wait;
  logic          commit;
  logic          c_we;
  logic [1:0]    c_size;
  logic          c_uns;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [AW-1:0] c_idx;
  logic          c_oob;
  logic          c_err;
  logic [31:0]   mem_word;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_aligned;
  logic [31:0]   rdata_ext;
  logic          misalign;

  always_comb begin
    req_ready = 1'b0;
    case (state_q)
      IDLE: req_ready = 1'b1;
`ifdef DMEM_BACK2BACK_EN
      RESP: req_ready = rsp_ready;
`else
      RESP: req_ready = 1'b0;
`endif
      default: req_ready = 1'b0;
    endcase
  end

  assign accept = req_valid && req_ready;

  // With no wait states the access commits in the accept cycle, straight from the request port.
  assign commit_from_req  = accept && (WAIT_STATES == 0);
  assign commit_from_wait = (state_q == WAIT) && (cnt_q == WS_LAST);
  assign commit           = commit_from_req || commit_from_wait;

  assign c_we    = commit_from_req ? req_we       : we_q;
  assign c_size  = commit_from_req ? req_size     : size_q;
  assign c_uns   = commit_from_req ? req_unsigned : uns_q;
  assign c_addr  = commit_from_req ? req_addr     : addr_q;
  assign c_wdata = commit_from_req ? req_wdata    : wdata_q;

  assign c_idx    = c_addr[AW+1:2];
  assign c_oob    = ({2'b00, c_addr[31:2]} >= 32'(DEPTH));
  assign mem_word = c_oob ? 32'h0 : memory[c_idx];
  assign c_err    = c_oob || (c_size == SZ_ILLEGAL) || misalign;

  dmem_lane_align u_lane_align (
    .size          (c_size),
    .is_unsigned   (c_uns),
    .addr_lo       (c_addr[1:0]),
    .wdata         (c_wdata),
    .rword         (mem_word),
    .byte_en       (byte_en),
    .wdata_aligned (wdata_aligned),
    .rdata_ext     (rdata_ext),
    .misalign      (misalign)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (commit_from_wait) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      we_d    = req_we;
      size_d  = req_size;
      uns_d   = req_unsigned;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      cnt_d   = 4'd0;
      state_d = (WAIT_STATES == 0) ? RESP : WAIT;
    end

    // A commit loads the response registers, overriding any consume in the same cycle.
    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = c_err;
      rsp_rdata_d = (c_err || c_we) ? 32'h0 : rdata_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Memory is never reset; a reset in the commit cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && commit && c_we && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) memory[c_idx][8*b +: 8] <= wdata_aligned[8*b +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed loads/stores checked against a word-array model, plus a zero-wait-state streaming run.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b1;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0 = 1'b0, req_we0 = 1'b0, rsp_ready0 = 1'b1;
  logic [31:0] req_addr0 = 32'h0, req_wdata0 = 32'h0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
    bit          seen;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [0:DEPTH-1];
  int          rec_cyc[$];
  logic [31:0] rec_data[$];
  logic        rec_err[$];

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0), .req_size(2'b10),
    .req_unsigned(1'b0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit modelErr(input logic [31:0] a, input logic [1:0] sz);
    if (int'(a / 4) >= DEPTH || a / 4 >= 32'(DEPTH)) return 1'b1;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] word, sh, v;
    word = model_mem[a / 4];
    sh   = word >> (8 * (a % 4));
    v    = word;
    if (sz == 2'd0) begin
      v = sh & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = sh & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic modelStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] mask, lane;
    if (sz == 2'd2) begin
      model_mem[a / 4] = wd;
    end else begin
      mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * (a % 4));
      lane = (wd & ((sz == 2'd0) ? 32'hFF : 32'hFFFF)) << (8 * (a % 4));
      model_mem[a / 4] = (model_mem[a / 4] & ~mask) | lane;
    end
  endtask

  // Compare process: every response cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
      end else begin
        if (!exp_q[0].seen) begin
          checkOutput("rsp_latency_cycle", 32'(cyc), 32'(exp_q[0].due));
          exp_q[0].seen = 1'b1;
        end
        checkOutput("rsp_rdata", rsp_rdata, exp_q[0].data);
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst && rsp_valid0 && rsp_ready0) begin
      rec_cyc.push_back(cyc);
      rec_data.push_back(rsp_rdata0);
      rec_err.push_back(rsp_err0);
    end
  end

  // Called at posedge+1 with the responder idle; returns at posedge+1 just after the accept edge.
  task automatic applyStimulus(input logic we, input logic [1:0] sz, input logic uns,
                               input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.err  = modelErr(a, sz);
    e.data = (e.err || we) ? 32'h0 : modelLoad(a, sz, uns);
    e.seen = 1'b0;
    if (we && !e.err) modelStore(a, sz, wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    @(negedge clk);
    checkOutput("req_ready_idle", 32'(req_ready), 32'h1);
    e.due = cyc + 1 + WS;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) return;
    end
    checkOutput("rsp_timeout_pending", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic checkLit(input string name, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] lit);
    bit got;
    got = 1'b0;
    applyStimulus(1'b0, sz, uns, a, 32'h0);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    if (got) checkOutput(name, rsp_rdata, lit);
    else     checkOutput({name, "_timeout"}, 32'h0, 32'h1);
    waitIdle();
  endtask

  initial begin
    int gap;
    bit got;
    int i;
    int guard;
    bit acc;
    logic [31:0] vals [0:3];

    vals[0] = 32'hCAFE0001; vals[1] = 32'h8000FFFF; vals[2] = 32'h01020304; vals[3] = 32'h7FFFFFFE;

    // Power-on reset and reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'h1);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'h0);
    @(posedge clk); #1;

    // Known contents
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h00, 32'h11223344); waitIdle();
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h04, 32'h55667788); waitIdle();
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hA5A5A5A5); waitIdle();

    // Reset in the middle of a store's wait state
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("postreset_req_ready", 32'(req_ready), 32'h1);
    checkOutput("postreset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("postreset_mem4", dut.memory[4], 32'hA5A5A5A5);
    @(posedge clk); #1;

    // Word store/load and byte lanes
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h08, 32'h12345678); waitIdle();
    checkLit("lw_0x08", 2'd2, 1'b0, 32'h08, 32'h12345678);
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h09, 32'h00000080); waitIdle();
    checkLit("lb_0x09", 2'd0, 1'b0, 32'h09, 32'hFFFFFF80);
    checkLit("lbu_0x09", 2'd0, 1'b1, 32'h09, 32'h00000080);
    checkOutput("mem2_after_sb", dut.memory[2], 32'h12348078);

    // Halfword lanes and more extension cases
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h06, 32'h00009ABC); waitIdle();
    checkLit("lh_0x06", 2'd1, 1'b0, 32'h06, 32'hFFFF9ABC);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h06, 32'h0); waitIdle();
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h02, 32'h0); waitIdle();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h04, 32'h0); waitIdle();
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h03, 32'h0); waitIdle();
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h03, 32'h000000F1); waitIdle();
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h00, 32'h0); waitIdle();

    // Error accesses: misaligned, out of range, illegal size
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h03, 32'h0); waitIdle();
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h06, 32'h0); waitIdle();
    applyStimulus(1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0); waitIdle();
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h08, 32'h0); waitIdle();
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h03, 32'h0000FFFF); waitIdle();
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h06, 32'hFFFFFFFF); waitIdle();
    applyStimulus(1'b1, 2'd3, 1'b0, 32'h08, 32'hFFFFFFFF); waitIdle();
    applyStimulus(1'b1, 2'd2, 1'b0, 32'(4 * DEPTH + 8), 32'hFFFFFFFF); waitIdle();
    for (int k = 0; k < 5; k++) checkOutput($sformatf("mem%0d_unchanged", k), dut.memory[k], model_mem[k]);

    // Response back-pressure
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    checkOutput("stall_rsp_seen", 32'(got), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("stall_rsp_rdata", rsp_rdata, 32'h12348078);
      checkOutput("stall_req_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("release_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("release_req_ready", 32'(req_ready), 32'h1);
    waitIdle();

    // Zero wait states: stream 4 stores then 4 loads with rsp_ready held high
    i = 0; guard = 0;
    while (i < 8 && guard < 100) begin
      req_valid0 = 1'b1;
      req_we0    = (i < 4);
      req_addr0  = 32'h40 + 32'(4 * (i % 4));
      req_wdata0 = vals[i % 4];
      @(negedge clk);
      acc = req_ready0;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    req_valid0 = 1'b0;
    for (int k = 0; k < 20 && rec_cyc.size() < 8; k++) @(posedge clk);
    #1;
    checkOutput("stream_rsp_count", 32'(rec_cyc.size()), 32'd8);
`ifdef DMEM_BACK2BACK_EN
    gap = 1;
`else
    gap = 2;
`endif
    if (rec_cyc.size() == 8) begin
      for (int k = 1; k < 8; k++)
        checkOutput($sformatf("stream_gap_%0d", k), 32'(rec_cyc[k] - rec_cyc[k-1]), 32'(gap));
      for (int k = 0; k < 8; k++) begin
        checkOutput($sformatf("stream_rdata_%0d", k), rec_data[k], (k < 4) ? 32'h0 : vals[k-4]);
        checkOutput($sformatf("stream_err_%0d", k), 32'(rec_err[k]), 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
